// File: rtl/mips_ctrl_pkg.sv
// Shared control-unit types for the pipelined MIPS core.
// Holds opcode codes, control-word structs, bubble constants and forward selects.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_LWU   = 6'h27;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [2:0] CLS_LOAD  = 3'b100;
   localparam logic [2:0] CLS_STORE = 3'b101;

   localparam logic [1:0] SIZE_NONE = 2'b11;

   localparam logic [1:0] FWD_NONE  = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   typedef struct packed {
      logic [3:0] aluOp;
      logic       aluSrc;
      logic       regDst;
      logic       isJump;
      logic       isUncond;
      logic       isEq;
      logic       memWrite;
      logic [1:0] dataSize;
      logic       regWrite;
      logic       wbFromAlu;
   } ctrl_t;

   typedef struct packed {
      logic       memWrite;
      logic [1:0] dataSize;
      logic       regWrite;
      logic       wbFromAlu;
   } memCtrl_t;

   typedef struct packed {
      logic regWrite;
      logic wbFromAlu;
   } wbCtrl_t;

   localparam ctrl_t    BUBBLE     = '0;
   localparam memCtrl_t MEM_BUBBLE = '0;
   localparam wbCtrl_t  WB_BUBBLE  = '0;

   function automatic memCtrl_t toMem(ctrl_t c);
      return '{memWrite: c.memWrite, dataSize: c.dataSize,
               regWrite: c.regWrite, wbFromAlu: c.wbFromAlu};
   endfunction

   function automatic wbCtrl_t toWb(memCtrl_t c);
      return '{regWrite: c.regWrite, wbFromAlu: c.wbFromAlu};
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control-word decoder (legacy encoding).
// Ports: opcode in; ctrl (full control word) and isLoad out.
module ctrl_decode
   import mips_ctrl_pkg::*;
#(
   parameter int OPC_W = 6
) (
   input  logic [OPC_W-1:0] opcode,
   output ctrl_t            ctrl,
   output logic             isLoad
);

   logic [5:0] op;
   logic       isBr;
   logic       isSt;
   logic       isLd;

   assign op   = opcode[5:0];
   assign isBr = op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE};
   assign isSt = (op[5:3] == CLS_STORE);
   assign isLd = (op[5:3] == CLS_LOAD);

   assign isLoad = isLd;

   always_comb begin
      ctrl = BUBBLE;
      unique case (1'b1)
         op[5]:            ctrl.aluOp = 4'b0000;
         isBr:             ctrl.aluOp = 4'b0001;
         (op == OP_RTYPE): ctrl.aluOp = 4'b0010;
         default:          ctrl.aluOp = op[3:0];
      endcase
      ctrl.isJump    = isBr;
      ctrl.isUncond  = ~op[2];
      ctrl.isEq      = ~op[0];
      ctrl.memWrite  = isSt;
      ctrl.dataSize  = (isSt | isLd) ? op[1:0] : SIZE_NONE;
      ctrl.aluSrc    = op[5] | op[3];
      ctrl.regDst    = op inside {OP_RTYPE, OP_BEQ, OP_BNE,
                                  OP_SB, OP_SH, OP_SW};
      ctrl.wbFromAlu = !(op inside {OP_LB, OP_LH, OP_LW, OP_LWU,
                                    OP_LBU, OP_LHU, OP_LUI});
      ctrl.regWrite  = !(isSt | isBr);
   end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control: decode, ID/EX-EX/MEM-MEM/WB control regs, hazards, forwarding.
// Ports: ID opcode/rs/rt/wr_reg, branch/mem-busy in; PC/IFID enables, stage ctrl, fwd selects out.
module pipe_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int OPC_W  = 6,
   parameter int REG_W  = 5,
   parameter int FWD_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPC_W-1:0] id_opcode,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_wr_reg,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic [3:0]       ex_alu_op,
   output logic             ex_alu_src,
   output logic             ex_reg_dst,
   output logic             ex_is_jump,
   output logic             ex_is_uncond,
   output logic             ex_is_eq,
   output logic             mem_write,
   output logic [1:0]       mem_datasize,
   output logic             wb_reg_write,
   output logic             wb_from_alu,
   output logic [REG_W-1:0] wb_wr_reg,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   ctrl_t idCtrl;
   logic  idLoad;

   ctrl_decode #(.OPC_W(OPC_W)) uDecode (
      .opcode (id_opcode),
      .ctrl   (idCtrl),
      .isLoad (idLoad)
   );

   ctrl_t            idExCtrl;
   logic [REG_W-1:0] idExWr;
   logic [REG_W-1:0] idExRs;
   logic [REG_W-1:0] idExRt;
   logic             idExLoad;

   memCtrl_t         exMemCtrl;
   logic [REG_W-1:0] exMemWr;
   logic             exMemLoad;

   wbCtrl_t          memWbCtrl;
   logic [REG_W-1:0] memWbWr;
   logic             memWbLoad;

   logic exHitRs, exHitRt, memHitRs, memHitRt;
   logic fwdExA, fwdExB, fwdWbA, fwdWbB;
   logic hazard, hold, loadBubble;

   assign exHitRs  = (id_rs != '0) && (id_rs == idExWr) && idExCtrl.regWrite;
   assign exHitRt  = (id_rt != '0) && (id_rt == idExWr) && idExCtrl.regWrite;
   assign memHitRs = (id_rs != '0) && (id_rs == exMemWr) && exMemCtrl.regWrite;
   assign memHitRt = (id_rt != '0) && (id_rt == exMemWr) && exMemCtrl.regWrite;

   // With forwarding only a load in EX can't be bypassed in time.
   assign hazard = (FWD_EN != 0)
                 ? (idExLoad && (exHitRs || exHitRt))
                 : (exHitRs || exHitRt || memHitRs || memHitRt);

   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      hold       = 1'b0;
      loadBubble = 1'b0;
      if (!rst_n) begin
         hold = 1'b0;
      end else if (mem_busy) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         hold       = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         loadBubble = 1'b1;
      end else if (hazard) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         loadBubble = 1'b1;
      end
   end

   assign fwdExA = (idExRs != '0) && (idExRs == exMemWr) && exMemCtrl.regWrite;
   assign fwdExB = (idExRt != '0) && (idExRt == exMemWr) && exMemCtrl.regWrite;
   assign fwdWbA = (idExRs != '0) && (idExRs == memWbWr) && memWbCtrl.regWrite;
   assign fwdWbB = (idExRt != '0) && (idExRt == memWbWr) && memWbCtrl.regWrite;

   always_comb begin
      fwd_a = FWD_NONE;
      fwd_b = FWD_NONE;
      if ((FWD_EN != 0) && rst_n) begin
         if (fwdExA)      fwd_a = FWD_EXMEM;
         else if (fwdWbA) fwd_a = FWD_MEMWB;
         if (fwdExB)      fwd_b = FWD_EXMEM;
         else if (fwdWbB) fwd_b = FWD_MEMWB;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idExCtrl  <= BUBBLE;
         idExWr    <= '0;
         idExRs    <= '0;
         idExRt    <= '0;
         idExLoad  <= 1'b0;
         exMemCtrl <= MEM_BUBBLE;
         exMemWr   <= '0;
         exMemLoad <= 1'b0;
         memWbCtrl <= WB_BUBBLE;
         memWbWr   <= '0;
         memWbLoad <= 1'b0;
      end else if (!hold) begin
         memWbCtrl <= toWb(exMemCtrl);
         memWbWr   <= exMemWr;
         memWbLoad <= exMemLoad;
         exMemCtrl <= toMem(idExCtrl);
         exMemWr   <= idExWr;
         exMemLoad <= idExLoad;
         if (loadBubble) begin
            idExCtrl <= BUBBLE;
            idExWr   <= '0;
            idExRs   <= '0;
            idExRt   <= '0;
            idExLoad <= 1'b0;
         end else begin
            idExCtrl <= idCtrl;
            idExWr   <= id_wr_reg;
            idExRs   <= id_rs;
            idExRt   <= id_rt;
            idExLoad <= idLoad;
         end
      end
   end

   // MEM/WB load flag is kept for datapath debug visibility only.
   logic unusedLoad;
   assign unusedLoad = memWbLoad & 1'b0;

   assign ex_alu_op    = idExCtrl.aluOp;
   assign ex_alu_src   = idExCtrl.aluSrc;
   assign ex_reg_dst   = idExCtrl.regDst;
   assign ex_is_jump   = idExCtrl.isJump;
   assign ex_is_uncond = idExCtrl.isUncond;
   assign ex_is_eq     = idExCtrl.isEq;
   assign mem_write    = exMemCtrl.memWrite;
   assign mem_datasize = exMemCtrl.dataSize;
   assign wb_reg_write = memWbCtrl.regWrite;
   assign wb_from_alu  = memWbCtrl.wbFromAlu;
   assign wb_wr_reg    = memWbWr;

endmodule
